// File: rtl/operand_permu_mqueue.sv
// ----------------------------------------------------------------------------
// operand_permu_mqueue
//
// Operand queue that sits between the register-file banks and one functional
// unit. It collects one 64-bit word per bank, pushes each complete beat into a
// small data FIFO, and presents it to the consumer. When the consumer needs
// elements twice as wide, it splits each beat into two output beats with
// zero or sign extension. A command FIFO holds the element count, element
// width, conversion mode and target unit for each operation in flight. A
// credit counter tells the requester how many beats it may still issue.
//
// Ports
//   clk_i                 : clock
//   rst_i                 : synchronous active-high reset
//   flush_i               : synchronous flush, same effect as reset
//   cmd_i / cmd_valid_i   : command push (no backpressure)
//   cmd_pop_o             : pulses when the head command retires
//   operand_i             : NrBanks x 64-bit bank words
//   operand_valid_i       : per-bank valid; banks may arrive in any cycle
//   operand_issued_i      : requester issued one beat (takes one credit)
//   operand_queue_ready_o : a credit is available
//   operand_o             : converted output beat
//   operand_valid_o       : output beat valid, replicated per bank
//   operand_last_o        : final beat of the head command
//   operand_target_fu_o   : target unit of the head command
//   operand_ready_i       : consumer ready; any bit set accepts the beat
//
// conv encoding: 0 = None, 1 = Zext2, 2 = Sext2 (3 behaves as None).
// eew encoding:  0 = 8 bit, 1 = 16 bit, 2 = 32 bit, 3 = 64 bit.
// ----------------------------------------------------------------------------
module operand_permu_mqueue #(
    parameter int unsigned CmdBufDepth  = 2,
    parameter int unsigned DataBufDepth = 2,
    parameter int unsigned NrBanks      = 8,
    parameter int unsigned NrSlaves     = 1,
    parameter int unsigned VLEN         = 4096,
    parameter int unsigned FuWidth      = 3
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        flush_i,
    input  struct packed {
        logic [$clog2(VLEN+1)-1:0] elem_count;
        logic [1:0]                eew;
        logic [1:0]                conv;
        logic [FuWidth-1:0]        target_fu;
    }                                   cmd_i,
    input  logic                        cmd_valid_i,
    output logic                        cmd_pop_o,
    input  logic [NrBanks-1:0][63:0]    operand_i,
    input  logic [NrBanks-1:0]          operand_valid_i,
    input  logic                        operand_issued_i,
    output logic                        operand_queue_ready_o,
    output logic [NrBanks-1:0][63:0]    operand_o,
    output logic [NrBanks-1:0]          operand_valid_o,
    output logic                        operand_last_o,
    output logic [FuWidth-1:0]          operand_target_fu_o,
    input  logic [NrSlaves-1:0]         operand_ready_i
);

    localparam int unsigned ElemCntW  = $clog2(VLEN + 1);
    localparam int unsigned CreditW   = $clog2(DataBufDepth) + 1;
    localparam int unsigned CmdPtrW   = (CmdBufDepth > 1) ? $clog2(CmdBufDepth) : 1;
    localparam int unsigned DataPtrW  = (DataBufDepth > 1) ? $clog2(DataBufDepth) : 1;
    localparam int unsigned CmdUsedW  = $clog2(CmdBufDepth + 1);
    localparam int unsigned DataUsedW = $clog2(DataBufDepth + 1);

    typedef enum logic [1:0] {
        ConvNone  = 2'd0,
        ConvZext2 = 2'd1,
        ConvSext2 = 2'd2
    } conv_e;

    typedef logic [NrBanks-1:0][63:0] beat_t;

    // Widen the elements of one 32-bit half word to twice their width.
    function automatic logic [63:0] widen(input logic [31:0] half, input logic [1:0] eew,
                                          input logic sext);
        logic [63:0] res;
        res = '0;
        case (eew)
            2'd0: begin
                for (int i = 0; i < 4; i++) begin
                    res[16*i +: 16] = {{8{sext & half[8*i+7]}}, half[8*i +: 8]};
                end
            end
            2'd1: begin
                for (int i = 0; i < 2; i++) begin
                    res[32*i +: 32] = {{16{sext & half[16*i+15]}}, half[16*i +: 16]};
                end
            end
            default: res = {{32{sext & half[31]}}, half};
        endcase
        return res;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [ElemCntW-1:0]  cmd_cnt_q  [CmdBufDepth];
    logic [ElemCntW-1:0]  cmd_cnt_d  [CmdBufDepth];
    logic [1:0]           cmd_eew_q  [CmdBufDepth];
    logic [1:0]           cmd_eew_d  [CmdBufDepth];
    conv_e                cmd_conv_q [CmdBufDepth];
    conv_e                cmd_conv_d [CmdBufDepth];
    logic [FuWidth-1:0]   cmd_fu_q   [CmdBufDepth];
    logic [FuWidth-1:0]   cmd_fu_d   [CmdBufDepth];
    logic [CmdPtrW-1:0]   cmd_wptr_q, cmd_wptr_d;
    logic [CmdPtrW-1:0]   cmd_rptr_q, cmd_rptr_d;
    logic [CmdUsedW-1:0]  cmd_used_q, cmd_used_d;

    beat_t                data_mem_q [DataBufDepth];
    beat_t                data_mem_d [DataBufDepth];
    logic [DataPtrW-1:0]  data_wptr_q, data_wptr_d;
    logic [DataPtrW-1:0]  data_rptr_q, data_rptr_d;
    logic [DataUsedW-1:0] data_used_q, data_used_d;

    beat_t                stage_data_q, stage_data_d;
    logic [NrBanks-1:0]   stage_flag_q, stage_flag_d;

    logic [CreditW-1:0]   credit_q, credit_d;
    logic [ElemCntW-1:0]  served_q, served_d;
    logic                 half_q, half_d;

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    beat_t                beat_in;
    beat_t                head_beat;
    beat_t                out_beat;
    logic                 data_push, data_wr, data_pop, data_full;
    logic                 cmd_wr, cmd_full;
    logic [ElemCntW-1:0]  head_cnt;
    logic [1:0]           head_eew;
    conv_e                head_conv;
    logic [FuWidth-1:0]   head_fu;
    logic                 conv_active;
    logic [1:0]           eew_out;
    logic [31:0]          beat_elems;
    logic [32:0]          served_sum;
    logic                 is_last;
    logic                 out_valid, accept, retire;

    // Bank staging: each bank is captured once; a beat is complete when every
    // bank is either already captured or arriving this cycle.
    always_comb begin
        stage_flag_d = stage_flag_q;
        stage_data_d = stage_data_q;
        beat_in      = '0;
        for (int b = 0; b < NrBanks; b++) begin
            beat_in[b] = stage_flag_q[b] ? stage_data_q[b] : operand_i[b];
            if (operand_valid_i[b] && !stage_flag_q[b]) begin
                stage_flag_d[b] = 1'b1;
                stage_data_d[b] = operand_i[b];
            end
        end
        data_push = &(stage_flag_q | operand_valid_i);
        if (data_push) begin
            stage_flag_d = '0;
        end
    end

    // Head command decode and output beat formation.
    always_comb begin
        head_cnt    = cmd_cnt_q[cmd_rptr_q];
        head_eew    = cmd_eew_q[cmd_rptr_q];
        head_conv   = cmd_conv_q[cmd_rptr_q];
        head_fu     = cmd_fu_q[cmd_rptr_q];
        head_beat   = data_mem_q[data_rptr_q];

        // 64-bit elements cannot be widened further, so they pass through.
        conv_active = ((head_conv == ConvZext2) || (head_conv == ConvSext2)) &&
                      (head_eew != 2'd3);
        eew_out     = conv_active ? head_eew + 2'd1 : head_eew;
        beat_elems  = 32'(NrBanks) << (2'd3 - eew_out);
        served_sum  = 33'(served_q) + 33'(beat_elems);
        is_last     = served_sum >= 33'(head_cnt);

        out_beat = '0;
        for (int b = 0; b < NrBanks; b++) begin
            if (conv_active) begin
                out_beat[b] = widen(half_q ? head_beat[b][63:32] : head_beat[b][31:0],
                                    head_eew, head_conv == ConvSext2);
            end else begin
                out_beat[b] = head_beat[b];
            end
        end

        out_valid = (data_used_q != '0) && (cmd_used_q != '0);
        accept    = out_valid && (|operand_ready_i);
        retire    = accept && is_last;
        // The last beat frees its input beat even if only the low half was used.
        data_pop  = accept && (is_last || !conv_active || half_q);
    end

    // Element counter and half-select.
    always_comb begin
        served_d = served_q;
        half_d   = half_q;
        if (accept) begin
            if (is_last) begin
                served_d = '0;
                half_d   = 1'b0;
            end else begin
                served_d = served_q + ElemCntW'(beat_elems);
                if (conv_active) begin
                    half_d = ~half_q;
                end
            end
        end
    end

    // Data FIFO.
    always_comb begin
        data_full  = (data_used_q == DataUsedW'(DataBufDepth));
        data_wr    = data_push && (!data_full || data_pop);
        data_mem_d = data_mem_q;
        if (data_wr) begin
            data_mem_d[data_wptr_q] = beat_in;
        end
        data_wptr_d = data_wptr_q;
        if (data_wr) begin
            data_wptr_d = (data_wptr_q == DataPtrW'(DataBufDepth - 1)) ? '0
                                                                      : data_wptr_q + 1'b1;
        end
        data_rptr_d = data_rptr_q;
        if (data_pop) begin
            data_rptr_d = (data_rptr_q == DataPtrW'(DataBufDepth - 1)) ? '0
                                                                      : data_rptr_q + 1'b1;
        end
        case ({data_wr, data_pop})
            2'b10:   data_used_d = data_used_q + 1'b1;
            2'b01:   data_used_d = data_used_q - 1'b1;
            default: data_used_d = data_used_q;
        endcase
    end

    // Command FIFO.
    always_comb begin
        cmd_full   = (cmd_used_q == CmdUsedW'(CmdBufDepth));
        cmd_wr     = cmd_valid_i && (!cmd_full || retire);
        cmd_cnt_d  = cmd_cnt_q;
        cmd_eew_d  = cmd_eew_q;
        cmd_conv_d = cmd_conv_q;
        cmd_fu_d   = cmd_fu_q;
        if (cmd_wr) begin
            cmd_cnt_d[cmd_wptr_q]  = cmd_i.elem_count;
            cmd_eew_d[cmd_wptr_q]  = cmd_i.eew;
            cmd_conv_d[cmd_wptr_q] = conv_e'(cmd_i.conv);
            cmd_fu_d[cmd_wptr_q]   = cmd_i.target_fu;
        end
        cmd_wptr_d = cmd_wptr_q;
        if (cmd_wr) begin
            cmd_wptr_d = (cmd_wptr_q == CmdPtrW'(CmdBufDepth - 1)) ? '0 : cmd_wptr_q + 1'b1;
        end
        cmd_rptr_d = cmd_rptr_q;
        if (retire) begin
            cmd_rptr_d = (cmd_rptr_q == CmdPtrW'(CmdBufDepth - 1)) ? '0 : cmd_rptr_q + 1'b1;
        end
        case ({cmd_wr, retire})
            2'b10:   cmd_used_d = cmd_used_q + 1'b1;
            2'b01:   cmd_used_d = cmd_used_q - 1'b1;
            default: cmd_used_d = cmd_used_q;
        endcase
    end

    // Credits: issued beats not yet popped from the data FIFO.
    always_comb begin
        case ({operand_issued_i, data_pop})
            2'b10:   credit_d = credit_q + 1'b1;
            2'b01:   credit_d = credit_q - 1'b1;
            default: credit_d = credit_q;
        endcase
    end

    // Control state; flush shares the reset path and overrides every update.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            cmd_wptr_q   <= '0;
            cmd_rptr_q   <= '0;
            cmd_used_q   <= '0;
            data_wptr_q  <= '0;
            data_rptr_q  <= '0;
            data_used_q  <= '0;
            stage_flag_q <= '0;
            credit_q     <= '0;
            served_q     <= '0;
            half_q       <= 1'b0;
        end else begin
            cmd_wptr_q   <= cmd_wptr_d;
            cmd_rptr_q   <= cmd_rptr_d;
            cmd_used_q   <= cmd_used_d;
            data_wptr_q  <= data_wptr_d;
            data_rptr_q  <= data_rptr_d;
            data_used_q  <= data_used_d;
            stage_flag_q <= stage_flag_d;
            credit_q     <= credit_d;
            served_q     <= served_d;
            half_q       <= half_d;
        end
    end

    // Storage needs no reset: occupancy and staging flags gate every use.
    always_ff @(posedge clk_i) begin
        cmd_cnt_q    <= cmd_cnt_d;
        cmd_eew_q    <= cmd_eew_d;
        cmd_conv_q   <= cmd_conv_d;
        cmd_fu_q     <= cmd_fu_d;
        data_mem_q   <= data_mem_d;
        stage_data_q <= stage_data_d;
    end

    assign operand_o             = out_beat;
    assign operand_valid_o       = {NrBanks{out_valid}};
    assign operand_last_o        = out_valid && is_last;
    assign operand_target_fu_o   = head_fu;
    assign cmd_pop_o             = retire;
    assign operand_queue_ready_o = (credit_q != CreditW'(DataBufDepth));

endmodule
